// File: rtl/ax301_peripherals_pkg.sv
// Shared types and constants for the AX301 board peripherals.
// Seven-segment section: the pin-level control bundle, the digit count,
// the all-off / none-selected patterns (both active-low) and the scan
// FSM state encoding.
package ax301_peripherals_pkg;

    // Pin bundle for the six-digit common-anode display, both fields active-low.
    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] segment;
    } ax301_segment_ctrl;

    localparam int         SEG_DIGITS = 6;
    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam logic [5:0] SEL_NONE   = 6'h3F;

    typedef enum logic {
        BLANK,
        SHOW
    } seg_scan_state_t;

endpackage

// File: rtl/ax301_hex7seg_decoder.sv
// Hex nibble to seven-segment pattern, active-low, bit order g,f,e,d,c,b,a.
// Purely combinational so the software-driven display path can share it.
// Ports:
//   nibble  in  4 : hex value 0..F
//   pattern out 7 : active-low segment pattern (decimal point not included)
module ax301_hex7seg_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = 7'h7F;
        case (nibble)
            4'h0: pattern = 7'h40;
            4'h1: pattern = 7'h79;
            4'h2: pattern = 7'h24;
            4'h3: pattern = 7'h30;
            4'h4: pattern = 7'h19;
            4'h5: pattern = 7'h12;
            4'h6: pattern = 7'h02;
            4'h7: pattern = 7'h78;
            4'h8: pattern = 7'h00;
            4'h9: pattern = 7'h10;
            4'hA: pattern = 7'h08;
            4'hB: pattern = 7'h03;
            4'hC: pattern = 7'h46;
            4'hD: pattern = 7'h21;
            4'hE: pattern = 7'h06;
            4'hF: pattern = 7'h0E;
            default: pattern = 7'h7F;
        endcase
    end

endmodule

// File: rtl/ax301_segment_scan.sv
// Time-multiplexed scan driver for the AX301 six-digit seven-segment display.
// Each digit owns a slot of CLK_DIV cycles; the first BLANK_CYCLES of every
// slot drive all segments off so the previous digit never ghosts onto the
// next. Inputs are snapshotted once per frame so a frame is always coherent.
// Ports:
//   clk, nrst   : system clock, asynchronous active-low reset
//   enable      : scan enable; low forces the display dark and restarts the scan
//   digit_data  : six hex nibbles, nibble i drives digit i
//   dp_en       : per-digit decimal point
//   digit_en    : per-digit enable (disabled digits still consume their slot)
//   seg_ctrl    : registered sel/segment, both active-low
//   frame_done  : one-cycle pulse at the end of each six-digit frame
module ax301_segment_scan
    import ax301_peripherals_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              enable,
    input  logic [23:0]       digit_data,
    input  logic [5:0]        dp_en,
    input  logic [5:0]        digit_en,
    output ax301_segment_ctrl seg_ctrl,
    output logic              frame_done
);

    localparam int             CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [2:0]     IDX_MAX   = 3'(SEG_DIGITS - 1);

    if (CLK_DIV < BLANK_CYCLES + 1 || CLK_DIV > (1 << 20)) begin : g_bad_clk_div
        $error("ax301_segment_scan: CLK_DIV out of range");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES > CLK_DIV - 1) begin : g_bad_blank
        $error("ax301_segment_scan: BLANK_CYCLES out of range");
    end

    logic [CW-1:0]                  cnt;
    logic [2:0]                     idx;
    logic [SEG_DIGITS-1:0][3:0]     snap_data;
    logic [SEG_DIGITS-1:0]          snap_dp;
    logic [SEG_DIGITS-1:0]          snap_en;
    logic [SEG_DIGITS-1:0][6:0]     pat;

    seg_scan_state_t                state;
    logic [5:0]                     sel_d;
    logic [7:0]                     seg_d;
    logic                           fd_d;

    // Slot counter, digit index and once-per-frame snapshot.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt       <= '0;
            idx       <= '0;
            snap_data <= '0;
            snap_dp   <= '0;
            snap_en   <= '0;
        end else if (!enable) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            if (cnt == '0 && idx == '0) begin
                snap_data <= digit_data;
                snap_dp   <= dp_en;
                snap_en   <= digit_en;
            end
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // One decoder per digit; the active one is picked by idx below. The
    // snapshot is already loaded when SHOW starts because BLANK_CYCLES >= 1.
    for (genvar i = 0; i < SEG_DIGITS; i++) begin : g_dec
        ax301_hex7seg_decoder u_dec (
            .nibble  (snap_data[i]),
            .pattern (pat[i])
        );
    end

    always_comb begin
        state = (cnt < BLANK_END) ? BLANK : SHOW;
    end

    always_comb begin
        sel_d = SEL_NONE;
        seg_d = SEG_OFF;
        fd_d  = 1'b0;
        if (enable) begin
            fd_d = (idx == IDX_MAX) && (cnt == CNT_MAX);
            case (state)
                BLANK: ;
                SHOW: begin
                    if (snap_en[idx]) begin
                        sel_d = ~(6'b1 << idx);
                        seg_d = {~snap_dp[idx], pat[idx]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            seg_ctrl.sel     <= SEL_NONE;
            seg_ctrl.segment <= SEG_OFF;
            frame_done       <= 1'b0;
        end else begin
            seg_ctrl.sel     <= sel_d;
            seg_ctrl.segment <= seg_d;
            frame_done       <= fd_d;
        end
    end

endmodule

// File: tb/tb_ax301_segment_scan.sv
// Bench for ax301_segment_scan with CLK_DIV=8, BLANK_CYCLES=2.
// Hand-written per-digit expectations live in a vector table; a small timing
// model pushes the expected output for each cycle into a queue when the
// inputs are driven, and the entry is popped and compared on the next falling
// edge once the DUT has registered it.
module tb_ax301_segment_scan;
    import ax301_peripherals_pkg::*;

    localparam int CD = 8;
    localparam int BC = 2;

    logic              clk = 1'b0;
    logic              nrst = 1'b1;
    logic              enable = 1'b0;
    logic [23:0]       digit_data = '0;
    logic [5:0]        dp_en = '0;
    logic [5:0]        digit_en = '0;
    ax301_segment_ctrl seg_ctrl;
    logic              frame_done;

    ax301_segment_scan #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .enable     (enable),
        .digit_data (digit_data),
        .dp_en      (dp_en),
        .digit_en   (digit_en),
        .seg_ctrl   (seg_ctrl),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0]      data;
        logic [5:0]       dp;
        logic [5:0]       den;
        logic [5:0][5:0]  sel;
        logic [5:0][7:0]  seg;
    } vec_t;

    typedef struct {
        logic [5:0] sel;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    vec_t  vt [5];
    exp_t  q [$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    cur_vec = 0;
    int    m_cnt = 0, m_idx = 0, m_snap = 0;
    bit    chk_on = 1'b0;
    int    viol = 0;
    int    fd_count = 0;
    int    tcount = 0;
    logic [5:0] prev_sel = 6'h3F;
    string tag = "";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int v);
        cur_vec    = v;
        digit_data = vt[v].data;
        dp_en      = vt[v].dp;
        digit_en   = vt[v].den;
    endtask

    // Called just after a falling edge with the inputs for this cycle set.
    task automatic tick();
        exp_t e;
        e.sel = 6'h3F;
        e.seg = 8'hFF;
        e.fd  = 1'b0;
        if (!enable) begin
            m_cnt = 0;
            m_idx = 0;
        end else begin
            if (m_cnt == 0 && m_idx == 0) m_snap = cur_vec;
            if (m_cnt >= BC) begin
                e.sel = vt[m_snap].sel[m_idx];
                e.seg = vt[m_snap].seg[m_idx];
            end
            e.fd = (m_idx == 5 && m_cnt == CD - 1);
            m_cnt++;
            if (m_cnt == CD) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 6;
            end
        end
        q.push_back(e);
        @(negedge clk);
        tcount++;
        e = q.pop_front();
        if (chk_on) begin
            check($sformatf("%s sel t=%0d", tag, tcount), 32'(seg_ctrl.sel), 32'(e.sel));
            check($sformatf("%s seg t=%0d", tag, tcount), 32'(seg_ctrl.segment), 32'(e.seg));
            check($sformatf("%s frame_done t=%0d", tag, tcount), 32'(frame_done), 32'(e.fd));
        end
        if ($countones(~seg_ctrl.sel) > 1) viol++;
        if (prev_sel != 6'h3F && seg_ctrl.sel != 6'h3F && seg_ctrl.sel != prev_sel) viol++;
        prev_sel = seg_ctrl.sel;
        if (frame_done) fd_count++;
    endtask

    task automatic restart(input int v);
        enable = 1'b0;
        apply(v);
        tick();
        enable = 1'b1;
        tcount = 0;
        fd_count = 0;
    endtask

    initial begin
        vt[0] = '{data: 24'h543210, dp: 6'h00, den: 6'h3F,
                  sel: {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                  seg: {8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}};
        vt[1] = '{data: 24'h543210, dp: 6'h01, den: 6'h3D,
                  sel: {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3F, 6'h3E},
                  seg: {8'h92, 8'h99, 8'hB0, 8'hA4, 8'hFF, 8'h40}};
        vt[2] = '{data: 24'hFEDCBA, dp: 6'h00, den: 6'h3F,
                  sel: {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                  seg: {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88}};
        vt[3] = '{data: 24'h109876, dp: 6'h2A, den: 6'h3F,
                  sel: {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                  seg: {8'h79, 8'hC0, 8'h10, 8'h80, 8'h78, 8'h82}};
        vt[4] = '{data: 24'h000000, dp: 6'h3F, den: 6'h00,
                  sel: {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F},
                  seg: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};

        // Power-on reset: outputs settle without any clock edge.
        #1 nrst = 1'b0;
        #1;
        check("por sel", 32'(seg_ctrl.sel), 32'h3F);
        check("por seg", 32'(seg_ctrl.segment), 32'hFF);
        check("por frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        chk_on = 1'b1;

        // Table vectors: two full frames each from a fresh start.
        for (int v = 0; v < 5; v++) begin
            tag = $sformatf("vec%0d", v);
            restart(v);
            for (int k = 0; k < 2 * 6 * CD + 2; k++) tick();
            check($sformatf("vec%0d frame_done count", v), 32'(fd_count), 32'd2);
        end

        // Reset mid-scan, asserted between clock edges.
        tag = "rst";
        restart(0);
        for (int k = 0; k < 20; k++) tick();
        check("rst pre sel lit", 32'(seg_ctrl.sel == 6'h3F), 32'd0);
        #2 nrst = 1'b0;
        #1;
        check("rst async sel", 32'(seg_ctrl.sel), 32'h3F);
        check("rst async seg", 32'(seg_ctrl.segment), 32'hFF);
        check("rst async frame_done", 32'(frame_done), 32'h0);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        m_cnt = 0;
        m_idx = 0;
        prev_sel = 6'h3F;

        // Coherent snapshot: new data arrives during digit 3.
        tag = "snap";
        restart(0);
        for (int k = 0; k < 28; k++) tick();
        apply(2);
        for (int k = 0; k < 70; k++) tick();

        // Enable dropped during digit 4: dark, no frame_done, clean restart.
        tag = "ena";
        restart(0);
        for (int k = 0; k < 36; k++) tick();
        enable = 1'b0;
        fd_count = 0;
        for (int k = 0; k < 20; k++) tick();
        check("ena off frame_done count", 32'(fd_count), 32'd0);
        enable = 1'b1;
        begin
            int lat;
            lat = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                lat++;
                if (seg_ctrl.sel != 6'h3F) break;
            end
            check("ena digit0 latency", 32'(lat), 32'd3);
            check("ena digit0 sel", 32'(seg_ctrl.sel), 32'h3E);
        end

        // Random data over 1000 frames: no overlap, blank between digits.
        tag = "rand";
        chk_on = 1'b0;
        restart(0);
        viol = 0;
        for (int k = 0; k < 1000 * 6 * CD; k++) begin
            if ($urandom_range(4) == 0) begin
                digit_data = 24'($urandom);
                dp_en      = 6'($urandom);
                digit_en   = 6'($urandom) | 6'h21;
            end
            tick();
        end
        check("rand overlap violations", 32'(viol), 32'd0);
        check("rand frame_done count", 32'(fd_count), 32'd1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ax301_segment_scan.md
# ax301_segment_scan

Hardware multiplexing driver for the AX301 six-digit, common-anode seven-segment display. It takes six hex nibbles plus per-digit decimal-point and enable masks from the register stage. It scans the digits in time, with a blanking gap between digits to suppress ghosting, and drives `ax301_segment_ctrl` to the pins. Software writes digit values once and no longer has to bit-bang the scan.

## Interface
Parameters:
- `CLK_DIV`, 50000: clock cycles per digit slot (1 ms at 50 MHz). Legal range is BLANK_CYCLES+1 to 2^20.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all segments off. Legal range is 1 to CLK_DIV-1.

Ports:
- `clk`  in  1: single system clock.
- `nrst`  in  1: asynchronous, active-low reset.
- `enable`  in  1: scan enable. When low, the display is dark.
- `digit_data`  in  24: nibble i = `digit_data[4i+3:4i]` is the hex value shown on digit i.
- `dp_en`  in  6: bit i lights the decimal point of digit i.
- `digit_en`  in  6: bit i = 0 blanks digit i. Its slot is still consumed.
- `seg_ctrl`  out  `ax301_segment_ctrl`: `sel[5:0]` and `segment[7:0]`, both active-low.
- `frame_done`  out  1: one-cycle pulse at the end of each full six-digit frame.

## Operation
- Slot counter `cnt` runs 0..CLK_DIV-1 and wraps. On each wrap the digit index `idx` advances 0..5, then 5 wraps to 0.
- Snapshot registers capture `digit_data`, `dp_en` and `digit_en` in the cycle where idx==0 and cnt==0.
  - All six digits of a frame come from one coherent sample.
  - Input changes mid-frame take effect only at the next frame start.
- Two-state FSM, derived from `cnt`:
  - BLANK while cnt < BLANK_CYCLES: `sel`=6'h3F, `segment`=8'hFF.
  - SHOW while cnt ≥ BLANK_CYCLES: `sel` = ~(1<<idx); `segment` = decode(snapshot nibble idx), with bit 7 cleared if dp_en[idx].
  - If digit_en[idx]=0, the SHOW outputs are `sel`=6'h3F and `segment`=8'hFF.
- Decode is active-low, bit order dp,g,f,e,d,c,b,a:
  - Digits 0-7: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8.
  - Digits 8-F: 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.
- `enable` low:
  - cnt and idx are synchronously forced to 0.
  - Outputs go dark; `frame_done` stays 0.
  - On return high, the scan restarts at idx 0, cnt 0 with a fresh snapshot.
- Reset, including mid-slot: asynchronously sets cnt=0, idx=0, snapshot=0, `sel`=6'h3F, `segment`=8'hFF, `frame_done`=0.

## Timing
- All outputs are registered. Each output reflects the (cnt, idx) of the previous cycle, giving one cycle of latency.
- The first cycle after `nrst` rises with `enable`=1 has cnt=0, idx=0.
  - Digit 0 becomes visible BLANK_CYCLES+1 cycles later.
  - Digit 0 stays visible for exactly CLK_DIV-BLANK_CYCLES cycles.
- Frame period is 6·CLK_DIV cycles. Each digit is blanked for exactly BLANK_CYCLES cycles per slot.
- `frame_done` is high for one cycle, in the cycle after idx==5 and cnt==CLK_DIV-1. This is coincident with the first blank output of the next frame.
- Only one `sel` bit is ever low at a time, and `sel` never changes directly from one digit to another without a blank in between.
- `cnt` width is $clog2(CLK_DIV). The comparison with BLANK_CYCLES is unsigned.

## Structure
- Add to `ax301_peripherals_pkg`:
  - `SEG_DIGITS`=6.
  - `SEG_OFF`=8'hFF and `SEL_NONE`=6'h3F.
  - A `seg_scan_state_t` enum {BLANK, SHOW}.
- Reuse the existing `ax301_segment_ctrl` typedef.
- Sub-module `ax301_hex7seg_decoder`: combinational, 4-bit nibble in, 7-bit active-low pattern out. It is reusable by the software-driven path.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
Benches use CLK_DIV=8 and BLANK_CYCLES=2 unless noted.
- Reset: hold `nrst`=0 mid-scan → `sel`=3F, `segment`=FF and `frame_done`=0 immediately, without waiting for a clock edge.
- Basic scan: digit_data=24'h543210, dp_en=0, digit_en=3F.
  - Per slot: 2 blank cycles, then 6 cycles of sel=3E/seg=C0, then 3D/F9, 3B/A4, 37/B0, 2F/99, 1F/92.
  - `frame_done` pulses every 48 cycles.
- DP and disable: dp_en=6'h01 and digit_en=6'h3D → digit 0 shows segment=40; digit 1's slot stays fully blank; other digits are unchanged.
- Coherent snapshot: change digit_data to 24'hFEDCBA during idx 3.
  - The rest of the frame still shows 3, 4, 5.
  - The next frame shows A, b, C, d, E, F (88, 83, C6, A1, 86, 8E).
- Enable toggle: drop `enable` during idx 4.
  - Outputs go dark the next cycle and no `frame_done` is generated.
  - On re-enable, digit 0 appears after 3 cycles.
- No overlap: random data over 1000 frames → a checker confirms at most one `sel` bit is low per cycle and a blank precedes every digit change.
